// File: rtl/cpu_axi_bridge_pkg.sv
// Shared types and constants for the CPU-to-AXI3 bridge: FSM states, access
// sizes, fixed AXI burst fields and default transaction IDs.
package cpu_axi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_ADDR_DATA,
    ST_WR_RESP
  } state_e;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Single-beat INCR bursts, no caching, locking or protection attributes.
  localparam logic [3:0] AXI_LEN0       = 4'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE      = 4'd0;
  localparam logic [1:0] AXI_LOCK       = 2'd0;
  localparam logic [2:0] AXI_PROT       = 3'd0;

  localparam int ID_W_DEF    = 4;
  localparam int INST_ID_DEF = 0;
  localparam int DATA_ID_DEF = 1;

  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/cpu_axi_bridge_if.sv
// Bus bundle between the core's SRAM-like ports, the bridge and the AXI3 slave.
// master = bridge view, slave = core plus interconnect view.
interface cpu_axi_bridge_if #(
  parameter int ID_W = 4
);

  logic            inst_req;
  logic [31:0]     inst_addr;
  logic            inst_addr_ok;
  logic            inst_data_ok;
  logic [31:0]     inst_rdata;

  logic            data_req;
  logic            data_wr;
  logic [1:0]      data_size;
  logic [31:0]     data_addr;
  logic [31:0]     data_wdata;
  logic            data_addr_ok;
  logic            data_data_ok;
  logic [31:0]     data_rdata;

  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [2:0]      arsize;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [2:0]      awsize;
  logic            awvalid;
  logic            awready;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic            bvalid;
  logic            bready;

  modport master (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output arid, araddr, arsize, arvalid,
    input  arready,
    input  rid, rdata, rlast, rvalid,
    output rready,
    output awid, awaddr, awsize, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bvalid,
    output bready
  );

  modport slave (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  arid, araddr, arsize, arvalid,
    output arready,
    output rid, rdata, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awsize, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bvalid,
    input  bready
  );

endinterface

// File: rtl/axi_wstrb_gen.sv
// Byte-lane strobe generator: maps access size and the low address bits to the
// AXI write strobes for a lane-aligned 32-bit write.
module axi_wstrb_gen
  import cpu_axi_bridge_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] wstrb
);

  always_comb begin
    // NOTE: assign a default first so every path drives wstrb and no latch is inferred.
    wstrb = 4'b1111;
    case (size)
      SIZE_BYTE: wstrb = 4'b0001 << addr_lo;
      SIZE_HALF: wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:   wstrb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/cpu_axi_bridge.sv
// Bridges the core's instruction and data SRAM-like ports onto one AXI3 master,
// data port first, with a single transaction in flight at any time.
module cpu_axi_bridge
  import cpu_axi_bridge_pkg::*;
#(
  parameter int ID_W    = ID_W_DEF,
  parameter int INST_ID = INST_ID_DEF,
  parameter int DATA_ID = DATA_ID_DEF
) (
  input logic              clk,
  input logic              rst,
  cpu_axi_bridge_if.master bus
);

  state_e      state;
  src_e        src_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic        aw_done, w_done;

  logic        idle, take_data, take_inst;
  logic        aw_hs, w_hs, rd_fin, wr_fin;
  logic [3:0]  wstrb;
  logic        unused_rsp;

  // Acceptance is combinational so the core sees addr_ok in the request cycle.
  assign idle      = rst && (state == ST_IDLE);
  assign take_data = idle && bus.data_req;
  assign take_inst = idle && !bus.data_req && bus.inst_req;

  assign aw_hs  = awvalid_q && bus.awready;
  assign w_hs   = wvalid_q && bus.wready;
  assign rd_fin = (state == ST_RD_DATA) && bus.rvalid;
  assign wr_fin = (state == ST_WR_RESP) && bus.bvalid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      src_q     <= SRC_INST;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      case (state)
        ST_IDLE: begin
          if (take_data) begin
            src_q   <= SRC_DATA;
            addr_q  <= bus.data_addr;
            size_q  <= bus.data_size;
            wdata_q <= bus.data_wdata;
            if (bus.data_wr) begin
              state     <= ST_WR_ADDR_DATA;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
            end else begin
              state     <= ST_RD_ADDR;
              arvalid_q <= 1'b1;
            end
          end else if (take_inst) begin
            src_q     <= SRC_INST;
            addr_q    <= bus.inst_addr;
            size_q    <= SIZE_WORD;
            wdata_q   <= '0;
            state     <= ST_RD_ADDR;
            arvalid_q <= 1'b1;
          end
        end
        ST_RD_ADDR: begin
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (bus.rvalid) begin
            rready_q <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_WR_ADDR_DATA: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done   <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            bready_q <= 1'b1;
            state    <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (bus.bvalid) begin
            bready_q <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  axi_wstrb_gen u_wstrb (
    .size    (size_q),
    .addr_lo (addr_q[1:0]),
    .wstrb   (wstrb)
  );

  assign bus.inst_addr_ok = take_inst;
  assign bus.data_addr_ok = take_data;
  assign bus.inst_data_ok = rd_fin && (src_q == SRC_INST);
  assign bus.data_data_ok = (rd_fin && (src_q == SRC_DATA)) || wr_fin;
  assign bus.inst_rdata   = bus.rdata;
  assign bus.data_rdata   = bus.rdata;

  assign bus.arid    = (src_q == SRC_DATA) ? ID_W'(DATA_ID) : ID_W'(INST_ID);
  assign bus.araddr  = addr_q;
  assign bus.arsize  = axi_size(size_q);
  assign bus.arvalid = arvalid_q;
  assign bus.rready  = rready_q;

  assign bus.awid    = ID_W'(DATA_ID);
  assign bus.awaddr  = addr_q;
  assign bus.awsize  = axi_size(size_q);
  assign bus.awvalid = awvalid_q;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = wstrb;
  assign bus.wlast   = wvalid_q;
  assign bus.wvalid  = wvalid_q;
  assign bus.bready  = bready_q;

  // Only one read is ever outstanding, so the response ID and last flag carry no information.
  assign unused_rsp = &{1'b0, bus.rid, bus.rlast};

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Self-checking bench for cpu_axi_bridge: directed scenarios plus random traffic
// checked cycle by cycle against a transaction-level model of the bridge.
module tb_cpu_axi_bridge;

  typedef struct {
    bit          rd;
    bit          src_data;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_axi_bridge_if #(.ID_W(4)) bus ();

  cpu_axi_bridge #(.ID_W(4), .INST_ID(0), .DATA_ID(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_iok = 0;
  int n_dok = 0;

  // core-side and slave-side stimulus knobs
  logic        c_inst_req, c_data_req, c_data_wr;
  logic [31:0] c_inst_addr, c_data_addr, c_data_wdata;
  logic [1:0]  c_data_size;
  logic        s_ar_rdy, s_aw_rdy, s_w_rdy, s_r_vld, s_b_vld;
  logic [31:0] s_rdata;

  // reference model: one outstanding transaction and its handshake progress
  bit   m_busy, m_ar_done, m_aw_done, m_w_done;
  txn_t cur;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_strb(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd0:    return 4'(1 << a);
      2'd1:    return 4'(3 << a);
      default: return 4'hF;
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ar_done = 0; m_aw_done = 0; m_w_done = 0;
    cur = '{rd: 1'b0, src_data: 1'b0, addr: 32'h0, wdata: 32'h0, size: 2'd0};
  endtask

  task automatic quiet();
    c_inst_req = 0; c_data_req = 0; c_data_wr = 0;
  endtask

  task automatic slave_all(input logic v);
    s_ar_rdy = v; s_aw_rdy = v; s_w_rdy = v; s_r_vld = v; s_b_vld = v;
  endtask

  // One clock cycle: drive, check against the model, advance the model, cross the edge.
  task automatic step();
    bit rd_ph, wr_ph, rv, bv, exp_dao, exp_iao;
    rd_ph = m_busy && cur.rd;
    wr_ph = m_busy && !cur.rd;
    rv = s_r_vld && rd_ph && m_ar_done;
    bv = s_b_vld && wr_ph && m_aw_done && m_w_done;

    bus.inst_req   = c_inst_req;
    bus.inst_addr  = c_inst_addr;
    bus.data_req   = c_data_req;
    bus.data_wr    = c_data_wr;
    bus.data_size  = c_data_size;
    bus.data_addr  = c_data_addr;
    bus.data_wdata = c_data_wdata;
    bus.arready    = s_ar_rdy;
    bus.awready    = s_aw_rdy;
    bus.wready     = s_w_rdy;
    bus.rvalid     = rv;
    bus.rdata      = s_rdata;
    bus.rid        = 4'(cur.src_data);
    bus.rlast      = rv;
    bus.bvalid     = bv;
    #1;

    exp_dao = !m_busy && c_data_req;
    exp_iao = !m_busy && !c_data_req && c_inst_req;
    check("data_addr_ok", 32'(bus.data_addr_ok), 32'(exp_dao));
    check("inst_addr_ok", 32'(bus.inst_addr_ok), 32'(exp_iao));
    check("inst_data_ok", 32'(bus.inst_data_ok), 32'(rv && !cur.src_data));
    check("data_data_ok", 32'(bus.data_data_ok), 32'((rv && cur.src_data) || bv));
    if (rv) check("rdata", cur.src_data ? bus.data_rdata : bus.inst_rdata, s_rdata);
    check("arvalid", 32'(bus.arvalid), 32'(rd_ph && !m_ar_done));
    check("rready",  32'(bus.rready),  32'(rd_ph && m_ar_done));
    check("awvalid", 32'(bus.awvalid), 32'(wr_ph && !m_aw_done));
    check("wvalid",  32'(bus.wvalid),  32'(wr_ph && !m_w_done));
    check("wlast",   32'(bus.wlast),   32'(wr_ph && !m_w_done));
    check("bready",  32'(bus.bready),  32'(wr_ph && m_aw_done && m_w_done));
    if (rd_ph && !m_ar_done) begin
      check("araddr", bus.araddr, cur.addr);
      check("arsize", 32'(bus.arsize), 32'(cur.size));
      check("arid",   32'(bus.arid), cur.src_data ? 32'd1 : 32'd0);
    end
    if (wr_ph && !m_aw_done) begin
      check("awaddr", bus.awaddr, cur.addr);
      check("awsize", 32'(bus.awsize), 32'(cur.size));
      check("awid",   32'(bus.awid), 32'd1);
    end
    if (wr_ph && !m_w_done) begin
      check("wdata", bus.wdata, cur.wdata);
      check("wstrb", 32'(bus.wstrb), 32'(exp_strb(cur.size, cur.addr[1:0])));
    end
    n_iok += int'(bus.inst_data_ok);
    n_dok += int'(bus.data_data_ok);

    if (exp_dao) begin
      cur = '{rd: !c_data_wr, src_data: 1'b1, addr: c_data_addr, wdata: c_data_wdata, size: c_data_size};
      m_busy = 1; m_ar_done = 0; m_aw_done = 0; m_w_done = 0;
    end else if (exp_iao) begin
      cur = '{rd: 1'b1, src_data: 1'b0, addr: c_inst_addr, wdata: 32'h0, size: 2'd2};
      m_busy = 1; m_ar_done = 0; m_aw_done = 0; m_w_done = 0;
    end else if (rd_ph) begin
      if (rv) m_busy = 0;
      else if (!m_ar_done && s_ar_rdy) m_ar_done = 1;
    end else if (wr_ph) begin
      if (bv) m_busy = 0;
      else begin
        if (s_aw_rdy) m_aw_done = 1;
        if (s_w_rdy)  m_w_done = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    model_reset();
    quiet();
    slave_all(1'b0);
    c_inst_addr = 32'h0; c_data_addr = 32'h0; c_data_wdata = 32'h0; c_data_size = 2'd0;
    s_rdata = 32'h0;

    // reset state, with both requests asserted to show addr_ok stays low
    rst = 1'b0;
    bus.inst_req = 1'b1; bus.inst_addr = 32'h0;
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_size = 2'd0;
    bus.data_addr = 32'h0; bus.data_wdata = 32'h0;
    bus.arready = 0; bus.awready = 0; bus.wready = 0;
    bus.rvalid = 0; bus.rdata = 32'h0; bus.rid = 4'h0; bus.rlast = 0; bus.bvalid = 0;
    #12;
    check("rst_arvalid", 32'(bus.arvalid), 32'd0);
    check("rst_awvalid", 32'(bus.awvalid), 32'd0);
    check("rst_wvalid",  32'(bus.wvalid),  32'd0);
    check("rst_rready",  32'(bus.rready),  32'd0);
    check("rst_bready",  32'(bus.bready),  32'd0);
    check("rst_iaok",    32'(bus.inst_addr_ok), 32'd0);
    check("rst_daok",    32'(bus.data_addr_ok), 32'd0);
    check("rst_idok",    32'(bus.inst_data_ok), 32'd0);
    check("rst_ddok",    32'(bus.data_data_ok), 32'd0);
    check("rst_araddr",  bus.araddr, 32'h0);
    check("rst_wdata",   bus.wdata,  32'h0);
    check("rst_arsize",  32'(bus.arsize), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // fetch with a zero-wait slave
    slave_all(1'b1);
    s_rdata = 32'h3C08_1234;
    c_inst_req = 1; c_inst_addr = 32'hBFC0_0000;
    n_iok = 0;
    step();
    quiet();
    step();
    step();
    check("fetch_iok_cnt", 32'(n_iok), 32'd1);

    // byte store to the top lane, response after three wait cycles
    s_b_vld = 0;
    c_data_req = 1; c_data_wr = 1; c_data_size = 2'd0;
    c_data_addr = 32'h8000_0003; c_data_wdata = 32'hAB00_0000;
    n_dok = 0;
    step();
    quiet();
    step();
    repeat (3) step();
    s_b_vld = 1;
    step();
    step();
    check("bstore_dok_cnt", 32'(n_dok), 32'd1);

    // simultaneous requests: data wins, fetch follows the cycle after data_ok
    slave_all(1'b1);
    s_rdata = 32'h1234_5678;
    c_data_req = 1; c_data_wr = 0; c_data_size = 2'd2; c_data_addr = 32'h8000_1000;
    c_inst_req = 1; c_inst_addr = 32'hBFC0_0004;
    n_dok = 0; n_iok = 0;
    step();
    c_data_req = 0;
    step();
    step();
    s_rdata = 32'h2408_0001;
    step();
    quiet();
    step();
    step();
    check("arb_dok_cnt", 32'(n_dok), 32'd1);
    check("arb_iok_cnt", 32'(n_iok), 32'd1);

    // arready held low for five cycles while the core keeps requesting
    s_ar_rdy = 0;
    c_inst_req = 1; c_inst_addr = 32'h0000_0040;
    n_iok = 0;
    step();
    repeat (5) step();
    c_inst_req = 0;
    s_ar_rdy = 1;
    step();
    step();
    step();
    check("arwait_iok_cnt", 32'(n_iok), 32'd1);

    // wready two cycles after awready
    slave_all(1'b1);
    s_w_rdy = 0;
    c_data_req = 1; c_data_wr = 1; c_data_size = 2'd1;
    c_data_addr = 32'h8000_0012; c_data_wdata = 32'hBEEF_0000;
    n_dok = 0;
    step();
    quiet();
    step();
    step();
    s_w_rdy = 1;
    step();
    step();
    step();
    check("wlag_dok_cnt", 32'(n_dok), 32'd1);

    // reset while waiting for read data
    slave_all(1'b1);
    s_r_vld = 0;
    c_inst_req = 1; c_inst_addr = 32'h1FC0_0100;
    step();
    quiet();
    step();
    #1;
    rst = 1'b0;
    #1;
    check("abort_arvalid", 32'(bus.arvalid), 32'd0);
    check("abort_rready",  32'(bus.rready),  32'd0);
    check("abort_awvalid", 32'(bus.awvalid), 32'd0);
    check("abort_wvalid",  32'(bus.wvalid),  32'd0);
    check("abort_bready",  32'(bus.bready),  32'd0);
    check("abort_idok",    32'(bus.inst_data_ok), 32'd0);
    model_reset();
    n_iok = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    s_r_vld = 1;
    repeat (3) step();
    check("abort_no_dok", 32'(n_iok), 32'd0);
    s_rdata = 32'h0000_0000;
    c_inst_req = 1; c_inst_addr = 32'hBFC0_0008;
    step();
    quiet();
    step();
    step();
    check("post_rst_iok", 32'(n_iok), 32'd1);

    // random traffic with random slave back-pressure
    for (int i = 0; i < 3000; i++) begin
      c_inst_req  = ($urandom_range(0, 99) < 50);
      c_data_req  = ($urandom_range(0, 99) < 40);
      c_data_wr   = ($urandom_range(0, 99) < 50);
      c_data_size = 2'($urandom_range(0, 2));
      a = $urandom;
      if (c_data_size == 2'd2) a[1:0] = 2'b00;
      else if (c_data_size == 2'd1) a[0] = 1'b0;
      c_data_addr  = a;
      c_data_wdata = $urandom;
      a = $urandom;
      c_inst_addr = {a[31:2], 2'b00};
      s_ar_rdy = ($urandom_range(0, 99) < 70);
      s_aw_rdy = ($urandom_range(0, 99) < 70);
      s_w_rdy  = ($urandom_range(0, 99) < 70);
      s_r_vld  = ($urandom_range(0, 99) < 60);
      s_b_vld  = ($urandom_range(0, 99) < 60);
      s_rdata  = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
